// File: rtl/al4s3b_wb_cmd_master.sv
// rtl/al4s3b_wb_cmd_master.sv - Wishbone master bridging a command/response handshake to FPGA IP
// One transfer at a time: IDLE accepts, BUS runs the Wishbone cycle with a timeout, RESP holds the result.
module al4s3b_wb_cmd_master #(
   parameter int unsigned TIMEOUT_CYCLES     = 15,
   parameter logic [31:0] TIMEOUT_READ_VALUE = 32'hBAD_FAB_AC
) (
   input  logic        WB_CLK,
   input  logic        WB_RST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [16:0] cmd_adr,
   input  logic [3:0]  cmd_byte_stb,
   input  logic [31:0] cmd_wdat,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdat,
   output logic        rsp_err,
   output logic [16:0] WBs_ADR,
   output logic        WBs_CYC,
   output logic [3:0]  WBs_BYTE_STB,
   output logic        WBs_WE,
   output logic        WBs_RD,
   output logic        WBs_STB,
   output logic [31:0] WBs_WR_DAT,
   input  logic [31:0] WBs_RD_DAT,
   input  logic        WBs_ACK,
   output logic [7:0]  err_cnt
);

   localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   state_t      r_state;
   logic        r_cmd_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdat;
   logic        r_rsp_err;
   logic [16:0] r_adr;
   logic [3:0]  r_byte_stb;
   logic [31:0] r_wr_dat;
   logic        r_we;
   logic        r_cyc;
   logic        r_wb_we;
   logic        r_wb_rd;
   logic [7:0]  r_tmo_cnt;
   logic [7:0]  r_err_cnt;

   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdat  <= 32'h0;
         r_rsp_err   <= 1'b0;
         r_adr       <= 17'h0;
         r_byte_stb  <= 4'h0;
         r_wr_dat    <= 32'h0;
         r_we        <= 1'b0;
         r_cyc       <= 1'b0;
         r_wb_we     <= 1'b0;
         r_wb_rd     <= 1'b0;
         r_tmo_cnt   <= 8'h0;
         r_err_cnt   <= 8'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_adr       <= cmd_adr;
                  r_byte_stb  <= cmd_byte_stb;
                  r_wr_dat    <= cmd_wdat;
                  r_we        <= cmd_we;
                  r_cyc       <= 1'b1;
                  r_wb_we     <= cmd_we;
                  r_wb_rd     <= ~cmd_we;
                  r_tmo_cnt   <= 8'h0;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_BUS;
               end
            end
            S_BUS: begin
               // An ACK on the last allowed cycle wins over the timeout.
               if (WBs_ACK) begin
                  r_rsp_rdat  <= r_we ? 32'h0 : WBs_RD_DAT;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_cyc       <= 1'b0;
                  r_wb_we     <= 1'b0;
                  r_wb_rd     <= 1'b0;
                  r_state     <= S_RESP;
               end else if (r_tmo_cnt == LP_TMO_LAST) begin
                  r_rsp_rdat  <= r_we ? 32'h0 : TIMEOUT_READ_VALUE;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_cyc       <= 1'b0;
                  r_wb_we     <= 1'b0;
                  r_wb_rd     <= 1'b0;
                  if (r_err_cnt != 8'hFF)
                     r_err_cnt <= r_err_cnt + 8'd1;
                  r_state     <= S_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_cyc       <= 1'b0;
               r_wb_we     <= 1'b0;
               r_wb_rd     <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready    = r_cmd_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdat     = r_rsp_rdat;
   assign rsp_err      = r_rsp_err;
   assign WBs_ADR      = r_adr;
   assign WBs_BYTE_STB = r_byte_stb;
   assign WBs_WR_DAT   = r_wr_dat;
   assign WBs_CYC      = r_cyc;
   assign WBs_STB      = r_cyc;
   assign WBs_WE       = r_wb_we;
   assign WBs_RD       = r_wb_rd;
   assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_al4s3b_wb_cmd_master.sv
// tb/tb_al4s3b_wb_cmd_master.sv - self-checking bench for al4s3b_wb_cmd_master
// Directed vector table, hand sequences for backpressure/reset, then random transfers against a model.
module tb_al4s3b_wb_cmd_master;

   localparam int          TMO = 15;
   localparam logic [31:0] TRV = 32'hBAD_FAB_AC;

   logic        WB_CLK = 1'b0;
   logic        WB_RST;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [16:0] cmd_adr;
   logic [3:0]  cmd_byte_stb;
   logic [31:0] cmd_wdat;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdat;
   logic [16:0] WBs_ADR;
   logic        WBs_CYC, WBs_WE, WBs_RD, WBs_STB, WBs_ACK;
   logic [3:0]  WBs_BYTE_STB;
   logic [31:0] WBs_WR_DAT, WBs_RD_DAT;
   logic [7:0]  err_cnt;

   al4s3b_wb_cmd_master #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_READ_VALUE(TRV)) dut (
      .WB_CLK(WB_CLK), .WB_RST(WB_RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_byte_stb(cmd_byte_stb), .cmd_wdat(cmd_wdat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdat(rsp_rdat), .rsp_err(rsp_err),
      .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_BYTE_STB(WBs_BYTE_STB), .WBs_WE(WBs_WE),
      .WBs_RD(WBs_RD), .WBs_STB(WBs_STB), .WBs_WR_DAT(WBs_WR_DAT),
      .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK), .err_cnt(err_cnt)
   );

   always #5 WB_CLK = ~WB_CLK;

   typedef struct {
      logic        we;
      logic [16:0] adr;
      logic [3:0]  stb;
      logic [31:0] wdat;
      int          ack_idx;   // BUS cycle index carrying ACK; >= TMO means never
      logic [31:0] slv_dat;
      int          bp;        // cycles rsp_ready stays low
      logic [31:0] exp_rdat;
      logic        exp_err;
      int          exp_cyc;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   model_err_cnt = 0;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge WB_CLK);
      #1;
   endtask

   // Reference model: outcome follows directly from when (if ever) the slave acknowledges.
   function automatic vec_t ref_model(input vec_t v);
      vec_t r = v;
      r.exp_err  = (v.ack_idx >= TMO);
      r.exp_cyc  = r.exp_err ? TMO : v.ack_idx + 1;
      r.exp_rdat = v.we ? 32'h0 : (r.exp_err ? TRV : v.slv_dat);
      return r;
   endfunction

   task automatic run_txn(input vec_t v);
      int          guard = 0;
      int          cyc_n = 0;
      logic        bad = 1'b0;
      logic        bp_bad = 1'b0;
      logic [55:0] exp_bus;
      while (!cmd_ready && guard < 50) begin tick(); guard++; end
      check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_byte_stb = v.stb; cmd_wdat = v.wdat;
      tick();
      cmd_valid = 1'b0; cmd_adr = 17'($urandom()); cmd_wdat = $urandom(); cmd_byte_stb = 4'($urandom());
      check("cyc_after_accept", 64'(WBs_CYC), 64'd1);
      exp_bus = {v.adr, v.stb, v.wdat, v.we, ~v.we, 1'b1};
      while (WBs_CYC && cyc_n < 40) begin
         if ({WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT, WBs_WE, WBs_RD, WBs_STB} !== exp_bus || cmd_ready)
            bad = 1'b1;
         WBs_ACK    = (cyc_n == v.ack_idx);
         WBs_RD_DAT = (cyc_n == v.ack_idx) ? v.slv_dat : $urandom();
         tick();
         cyc_n++;
      end
      WBs_ACK = 1'b0;
      check("bus_fields", 64'(bad), 64'd0);
      check("cyc_len", 64'(cyc_n), 64'(v.exp_cyc));
      check("rsp_valid_latency", 64'(rsp_valid), 64'd1);
      if (v.exp_err && model_err_cnt < 255) model_err_cnt++;
      for (int i = 0; i < v.bp; i++) begin
         WBs_ACK = 1'($urandom()); WBs_RD_DAT = $urandom();
         if (!rsp_valid || rsp_rdat !== v.exp_rdat || rsp_err !== v.exp_err || cmd_ready) bp_bad = 1'b1;
         tick();
      end
      WBs_ACK = 1'b0;
      check("rsp_hold", 64'(bp_bad), 64'd0);
      check("rsp_rdat", 64'(rsp_rdat), 64'(v.exp_rdat));
      check("rsp_err", 64'(rsp_err), 64'(v.exp_err));
      check("err_cnt", 64'(err_cnt), 64'(model_err_cnt));
      check("post_bus", 64'({WBs_ADR, WBs_WE, WBs_RD, WBs_STB}), 64'({v.adr, 3'b000}));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_done", 64'({rsp_valid, cmd_ready, WBs_CYC}), 64'(3'b010));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      logic bad;
      vecs[0] = '{1'b0, 17'h00000, 4'hF, 32'h0,         1,  32'h0,         0, 32'h0,         1'b0, 2};
      vecs[1] = '{1'b1, 17'h00008, 4'hF, 32'h1,         0,  32'hDEAD_BEEF, 0, 32'h0,         1'b0, 1};
      vecs[2] = '{1'b0, 17'h1FFFC, 4'h3, 32'h0,         99, 32'h0,         0, TRV,           1'b1, 15};
      vecs[3] = '{1'b0, 17'h00100, 4'hF, 32'h0,         14, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 15};
      vecs[4] = '{1'b1, 17'h10004, 4'h1, 32'hCAFE_0001, 99, 32'h0,         2, 32'h0,         1'b1, 15};
      vecs[5] = '{1'b0, 17'h0ABCD, 4'hC, 32'h0,         13, 32'hA5A5_5A5A, 3, 32'hA5A5_5A5A, 1'b0, 14};

      WB_RST = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_byte_stb = '0; cmd_wdat = '0;
      rsp_ready = 1'b0; WBs_ACK = 1'b0; WBs_RD_DAT = '0;
      tick(); tick();
      WB_RST = 1'b0;
      check("reset_hs", 64'({cmd_ready, rsp_valid, rsp_err}), 64'(3'b100));
      check("reset_rdat", 64'(rsp_rdat), 64'd0);
      check("reset_ctl", 64'({WBs_CYC, WBs_STB, WBs_WE, WBs_RD}), 64'd0);
      check("reset_bus", 64'({WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT}), 64'd0);
      check("reset_err_cnt", 64'(err_cnt), 64'd0);

      for (int i = 0; i < 6; i++) run_txn(vecs[i]);

      // Backpressure with a second command waiting
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00020; cmd_byte_stb = 4'hF;
      tick();
      cmd_adr = 17'h00040; cmd_we = 1'b1; cmd_wdat = 32'h5555_AAAA;
      WBs_ACK = 1'b1; WBs_RD_DAT = 32'h0BAD_CAFE;
      tick();
      WBs_ACK = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         WBs_RD_DAT = $urandom();
         if (!rsp_valid || rsp_rdat !== 32'h0BAD_CAFE || rsp_err || cmd_ready || WBs_CYC) bad = 1'b1;
         tick();
      end
      check("bp_stable", 64'(bad), 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_release", 64'({rsp_valid, cmd_ready, WBs_CYC}), 64'(3'b010));
      tick();
      cmd_valid = 1'b0;
      check("bp_second_cmd", 64'({WBs_CYC, WBs_WE, WBs_ADR, WBs_WR_DAT}),
            64'({1'b1, 1'b1, 17'h00040, 32'h5555_AAAA}));
      WBs_ACK = 1'b1;
      tick();
      WBs_ACK = 1'b0;
      check("bp_second_rsp", 64'({rsp_valid, rsp_err, rsp_rdat}), 64'({2'b10, 32'h0}));
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

      // Reset on the third BUS cycle
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00300;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();
      check("rst_bus_cyc_before", 64'(WBs_CYC), 64'd1);
      WB_RST = 1'b1;
      tick();
      WB_RST = 1'b0;
      model_err_cnt = 0;
      check("rst_bus_cyc_after", 64'(WBs_CYC), 64'd0);
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid || WBs_CYC || err_cnt != 8'd0) bad = 1'b1;
         tick();
      end
      check("rst_bus_quiet", 64'(bad), 64'd0);

      // Reset while a response is pending
      cmd_valid = 1'b1; cmd_we = 1'b0; tick(); cmd_valid = 1'b0;
      WBs_ACK = 1'b1; WBs_RD_DAT = 32'h7777_1111; tick(); WBs_ACK = 1'b0;
      check("rst_resp_pending", 64'(rsp_valid), 64'd1);
      WB_RST = 1'b1; tick(); WB_RST = 1'b0;
      check("rst_resp_discard", 64'({rsp_valid, cmd_ready, rsp_rdat}), 64'({2'b01, 32'h0}));

      for (int i = 0; i < 40; i++) begin
         v.we = 1'($urandom()); v.adr = 17'($urandom()); v.stb = 4'($urandom());
         v.wdat = $urandom(); v.ack_idx = $urandom_range(0, 19); v.slv_dat = $urandom();
         v.bp = $urandom_range(0, 3);
         run_txn(ref_model(v));
      end

      for (int i = 0; i < 256; i++) begin
         v.we = 1'($urandom()); v.adr = 17'($urandom()); v.stb = 4'hF; v.wdat = $urandom();
         v.ack_idx = 99; v.slv_dat = 32'h0; v.bp = 0;
         run_txn(ref_model(v));
      end
      check("err_cnt_saturated", 64'(err_cnt), 64'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/al4s3b_wb_cmd_master.md
AL4S3B_WB_CMD_MASTER -- requirements
Module: al4s3b_wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: bus cycles allowed for WBs_ACK before abort (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_READ_VALUE, default 32'hBAD_FAB_AC: read data returned on timeout.
REQ-003 SHALL have port WB_CLK  input  1  the only clock; all flops rise on it.
REQ-004 SHALL have port WB_RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_adr  input  17  byte address into the 128 KB FPGA aperture.
REQ-009 SHALL have port cmd_byte_stb  input  4  byte enables.
REQ-010 SHALL have port cmd_wdat  input  32  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_rdat  output  32  read data (0 for writes).
REQ-014 SHALL have port rsp_err  output  1  1 = transfer aborted by timeout.
REQ-015 SHALL have ports WBs_ADR (output, 17), WBs_CYC (output, 1), WBs_BYTE_STB (output, 4), WBs_WE (output, 1), WBs_RD (output, 1), WBs_STB (output, 1) and WBs_WR_DAT (output, 32): the Wishbone master outputs to the FPGA IP.
REQ-016 SHALL have ports WBs_RD_DAT (input, 32) and WBs_ACK (input, 1): the Wishbone slave returns.
REQ-017 SHALL have port err_cnt  output  8  count of timed-out transfers, saturating.

Function
REQ-018 SHALL implement the states IDLE, BUS and RESP.
REQ-019 In IDLE, SHALL drive cmd_ready=1; in every other state, SHALL drive cmd_ready=0.
REQ-020 When cmd_valid&cmd_ready is high in IDLE, SHALL register cmd_adr, cmd_byte_stb, cmd_we and cmd_wdat, and SHALL enter BUS on the next edge.
REQ-021 In BUS, SHALL drive WBs_CYC=WBs_STB=1, WBs_WE=we, WBs_RD=~we and the registered addr/stb/data, held stable for the whole cycle.
REQ-022 Outside BUS, SHALL drive WBs_CYC, WBs_STB, WBs_WE and WBs_RD to 0, and SHALL hold the address, byte-strobe and data outputs at their last values.
REQ-023 SHALL clear the timeout counter on entry to BUS and SHALL increment it once for each BUS cycle in which WBs_ACK=0.
REQ-024 On a BUS cycle with WBs_ACK=1, SHALL capture rsp_rdat (WBs_RD_DAT for a read, 0 for a write), set rsp_err=0 and enter RESP; the bus therefore deasserts on the following cycle.
REQ-025 On the BUS cycle in which the counter equals TIMEOUT_CYCLES-1 and WBs_ACK=0, SHALL load rsp_rdat=TIMEOUT_READ_VALUE for a read or 0 for a write, set rsp_err=1, increment err_cnt and enter RESP.
REQ-026 SHALL saturate err_cnt at 255.
REQ-027 If WBs_ACK=1 on the timeout cycle, SHALL treat the transfer as a normal ACK with no error.
REQ-028 In RESP, SHALL hold rsp_valid=1 and stable rsp_rdat/rsp_err until rsp_ready=1, then enter IDLE; no new command is accepted in that same cycle.
REQ-029 In IDLE and RESP, SHALL ignore WBs_ACK and WBs_RD_DAT.
REQ-030 Minimum latency SHALL be: accept at cycle N, CYC high at N+1, ACK at N+1 gives rsp_valid at N+2.

Reset
REQ-031 On WB_RST=1 at a clock edge, SHALL enter IDLE, set cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdat=0, WBs_CYC=WBs_STB=WBs_WE=WBs_RD=0, WBs_ADR=0, WBs_BYTE_STB=0, WBs_WR_DAT=0, clear the timeout counter and set err_cnt=0.
REQ-032 A reset during BUS SHALL abandon the transfer: CYC drops the next cycle, and no response or err_cnt update is generated.
REQ-033 A reset during RESP SHALL discard the pending response.

Verification
REQ-034 Read: cmd adr=17'h00000, we=0, slave ACKs after 2 cycles with 32'h0000_0000 -> one CYC window of 2 cycles, WBs_RD=1, rsp_rdat=0, rsp_err=0.
REQ-035 Write: adr=17'h00008, stb=4'hF, wdat=32'h1 with immediate ACK -> WBs_WE=1 for 1 cycle, rsp_rdat=0, rsp_err=0, rsp_valid on the second cycle after accept.
REQ-036 Timeout: read with ACK never asserted -> CYC high for exactly 15 cycles, rsp_rdat=32'hBAD_FAB_AC, rsp_err=1, err_cnt=1.
REQ-037 Race: ACK asserted exactly on the 15th BUS cycle -> rsp_err=0, rsp_rdat=WBs_RD_DAT, err_cnt unchanged.
REQ-038 Backpressure: rsp_ready held low for 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout, second cmd_valid held until accepted after handshake.
REQ-039 Reset mid-BUS: assert WB_RST on BUS cycle 3 -> CYC=0 the next cycle, rsp_valid never rises, err_cnt=0; 256 forced timeouts -> err_cnt=255.
